// File: rtl/seven_seg_scan_if.sv
// Display bus between the value source and the 7-segment scanner.
// master drives value/enable and observes the pins; slave is the scanner.
interface seven_seg_scan_if;
  logic [15:0] value;
  logic        enable;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  modport master (output value, enable, input an, seg, dp);
  modport slave  (input value, enable, output an, seg, dp);
endinterface

// File: rtl/seven_seg_scan.sv
// Four-digit multiplexed hex display driver with per-frame input sampling and
// inter-digit blanking. Optional LEADING_ZERO_BLANK_EN hides leading zero digits.
module seven_seg_scan #(
  parameter int unsigned DIGIT_PERIOD = 100000,
  parameter int unsigned BLANK_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  seven_seg_scan_if.slave  bus
);

  localparam int unsigned   CW       = (DIGIT_PERIOD > 1) ? $clog2(DIGIT_PERIOD) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIGIT_PERIOD - 1);

  logic [CW-1:0] cnt;
  logic [1:0]    digit;
  logic [15:0]   shadow;
  logic [3:0]    an_q;
  logic [6:0]    seg_q;

  logic          slot_end;
  logic          frame_end;
  logic          in_blank;
  logic          digit_on;
  logic [3:0]    nibble;
  logic [3:0]    an_d;
  logic [6:0]    seg_d;

  function automatic logic [6:0] hex_seg(input logic [3:0] n);
    case (n)
      4'h0: hex_seg = 7'b1000000;
      4'h1: hex_seg = 7'b1111001;
      4'h2: hex_seg = 7'b0100100;
      4'h3: hex_seg = 7'b0110000;
      4'h4: hex_seg = 7'b0011001;
      4'h5: hex_seg = 7'b0010010;
      4'h6: hex_seg = 7'b0000010;
      4'h7: hex_seg = 7'b1111000;
      4'h8: hex_seg = 7'b0000000;
      4'h9: hex_seg = 7'b0010000;
      4'hA: hex_seg = 7'b0001000;
      4'hB: hex_seg = 7'b0000011;
      4'hC: hex_seg = 7'b1000110;
      4'hD: hex_seg = 7'b0100001;
      4'hE: hex_seg = 7'b0000110;
      default: hex_seg = 7'b0001110;
    endcase
  endfunction

  assign slot_end  = (cnt == CNT_LAST);
  assign frame_end = slot_end && (digit == 2'd3);
  assign in_blank  = (32'(cnt) < BLANK_CYCLES);

  always_comb begin
    nibble = 4'h0;
    case (digit)
      2'd0: nibble = shadow[3:0];
      2'd1: nibble = shadow[7:4];
      2'd2: nibble = shadow[11:8];
      default: nibble = shadow[15:12];
    endcase
  end

`ifdef LEADING_ZERO_BLANK_EN
  // Highest non-zero nibble; digit 0 always counts as significant.
  logic [1:0] msd;
  always_comb begin
    msd = 2'd0;
    if (shadow[15:12] != 4'h0)     msd = 2'd3;
    else if (shadow[11:8] != 4'h0) msd = 2'd2;
    else if (shadow[7:4] != 4'h0)  msd = 2'd1;
  end
  assign digit_on = (digit <= msd);
`else
  assign digit_on = 1'b1;
`endif

  always_comb begin
    an_d  = 4'b1111;
    seg_d = 7'b1111111;
    if (bus.enable && !in_blank && digit_on) begin
      an_d  = ~(4'b0001 << digit);
      seg_d = hex_seg(nibble);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      digit  <= 2'd0;
      shadow <= 16'h0000;
    end else begin
      if (slot_end) begin
        cnt   <= '0;
        digit <= digit + 2'd1;
      end else begin
        cnt <= cnt + 1'b1;
      end
      // Sample only at the frame boundary so a frame never mixes two values.
      if (frame_end) shadow <= bus.value;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_q  <= 4'b1111;
      seg_q <= 7'b1111111;
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
    end
  end

  assign bus.an  = an_q;
  assign bus.seg = seg_q;
  assign bus.dp  = 1'b1;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Randomised self-checking bench for seven_seg_scan against a time-indexed
// behavioural model, plus directed literal checks of the main scenarios.
module tb_seven_seg_scan;
  localparam int P = 4;
  localparam int B = 1;

  logic clk;
  logic rst_n;
  seven_seg_scan_if bus ();

  seven_seg_scan #(.DIGIT_PERIOD(P), .BLANK_CYCLES(B)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic run_cmp = 1'b0;

  logic [6:0] hex_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Model: t = clocks since reset; the displayed position is a pure function of t.
  int          m_t;
  logic [15:0] m_sh;
  logic [3:0]  exp_an;
  logic [6:0]  exp_seg;

  function automatic logic [10:0] model_out(input int t, input logic [15:0] sh, input logic en);
    int c, d, ms;
    logic [3:0] nib;
    c  = t % P;
    d  = (t / P) % 4;
    ms = 0;
    for (int k = 0; k < 4; k++) if (((sh >> (4 * k)) & 16'hF) != 0) ms = k;
`ifndef LEADING_ZERO_BLANK_EN
    ms = 3;
`endif
    nib = 4'((sh >> (4 * d)) & 16'hF);
    if (!en || c < B || d > ms) return {4'b1111, 7'b1111111};
    return {~(4'b0001 << d), hex_tab[nib]};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_t     <= 0;
      m_sh    <= 16'h0000;
      exp_an  <= 4'b1111;
      exp_seg <= 7'b1111111;
    end else begin
      {exp_an, exp_seg} <= model_out(m_t, m_sh, bus.enable);
      if ((m_t % (4 * P)) == 4 * P - 1) m_sh <= bus.value;
      m_t <= m_t + 1;
    end
  end

  always @(negedge clk) begin
    if (run_cmp) begin
      chk("an", 32'(bus.an), 32'(exp_an));
      chk("seg", 32'(bus.seg), 32'(exp_seg));
      chk("dp", 32'(bus.dp), 32'd1);
      chk("one_hot_an", 32'($countones(~bus.an) <= 1), 32'd1);
    end
  end

  // Returns at the negedge where outputs reflect model state index 'target' (mod m).
  task automatic wait_shown(input int target, input int m);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (m_t > 0 && ((m_t - 1) % m) == target) ok = 1'b1;
    end
    if (!ok) chk("wait_timeout", 32'd0, 32'd1);
  endtask

  logic [3:0] lit_an [16] = '{
    4'b1111, 4'b1110, 4'b1110, 4'b1110, 4'b1111, 4'b1101, 4'b1101, 4'b1101,
    4'b1111, 4'b1011, 4'b1011, 4'b1011, 4'b1111, 4'b0111, 4'b0111, 4'b0111};
  logic [6:0] lit_seg [4] = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};

  initial begin
    logic [15:0] v;
    rst_n      = 1'b0;
    bus.value  = 16'h1234;
    bus.enable = 1'b1;
    run_cmp    = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_an", 32'(bus.an), 32'hF);
    chk("reset_seg", 32'(bus.seg), 32'h7F);
    rst_n = 1'b1;

    wait_shown(1, 1 << 30);
    chk("first_frame_an", 32'(bus.an), 32'hE);
    chk("first_frame_zero", 32'(bus.seg), 32'(7'b1000000));

    for (int i = 0; i < 16; i++) begin
      wait_shown(16 + i, 1 << 30);
      chk("frame2_an", 32'(bus.an), 32'(lit_an[i]));
      chk("frame2_seg", 32'(bus.seg), (i % 4 == 0) ? 32'h7F : 32'(lit_seg[i / 4]));
    end

    wait_shown(5, 16);
    bus.value = 16'hFFFF;
    wait_shown(13, 16);
    chk("no_tear_digit3", 32'(bus.seg), 32'(7'b1111001));
    wait_shown(1, 16);
    chk("new_frame_F", 32'(bus.seg), 32'(7'b0001110));
    chk("new_frame_an", 32'(bus.an), 32'hE);

    wait_shown(2, 4);
    bus.enable = 1'b0;
    @(negedge clk);
    chk("disable_an", 32'(bus.an), 32'hF);
    chk("disable_seg", 32'(bus.seg), 32'h7F);
    repeat (4) @(negedge clk);
    bus.enable = 1'b1;
    repeat (10) @(negedge clk);

    wait_shown(10, 16);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_an", 32'(bus.an), 32'hF);
    chk("async_reset_seg", 32'(bus.seg), 32'h7F);
    @(negedge clk);
    rst_n = 1'b1;
    wait_shown(1, 1 << 30);
    chk("post_reset_zero", 32'(bus.seg), 32'(7'b1000000));
    chk("post_reset_an", 32'(bus.an), 32'hE);

    bus.value = 16'h00A5;
    wait_shown(1, 16);
    wait_shown(13, 16);
`ifdef LEADING_ZERO_BLANK_EN
    chk("lzb_digit3_off", 32'(bus.an), 32'hF);
`else
    chk("digit3_zero_an", 32'(bus.an), 32'h7);
    chk("digit3_zero_seg", 32'(bus.seg), 32'(7'b1000000));
`endif

    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if ($urandom_range(0, 9) == 0) begin
        v = 16'($urandom);
        case ($urandom_range(0, 4))
          0: v = v & 16'h0FFF;
          1: v = v & 16'h00FF;
          2: v = v & 16'h000F;
          3: v = 16'h0000;
          default: ;
        endcase
        bus.value = v;
      end
      bus.enable = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 599) == 0) begin
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    run_cmp = 1'b0;
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
